// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with zero-latency hits and a WORDS_PER_LINE-cycle line refill.
// Define INST_CACHE_PERF_CNT_EN to add the hit_cnt / miss_cnt performance counter outputs.
module inst_cache #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
`ifdef INST_CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [31:0]            data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]       tags_q [NUM_LINES];

  logic [OFF_W-1:0]       req_off;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   lookup_hit;
  logic                   hit_evt, miss_evt, fill_we, fill_last;
  logic [1:0]             unused_byte_off;

  assign req_off         = cpu_addr[OFF_W+1:2];
  assign req_idx         = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag         = cpu_addr[31:IDX_W+OFF_W+2];
  assign unused_byte_off = cpu_addr[1:0];
  assign lookup_hit      = valid_q[req_idx] && (tags_q[req_idx] == req_tag);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    cpu_stall = 1'b0;
    cpu_instr = '0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;

    if (flush) begin
      // Flush wins over any lookup or refill in progress.
      valid_d   = '0;
      state_d   = IDLE;
      cpu_stall = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (lookup_hit) begin
              cpu_instr = data_q[req_idx][req_off];
              hit_evt   = 1'b1;
            end else begin
              cpu_stall = 1'b1;
              miss_evt  = 1'b1;
              tag_d     = req_tag;
              idx_d     = req_idx;
              cnt_d     = '0;
              state_d   = REFILL;
            end
          end
        end
        REFILL: begin
          cpu_stall = 1'b1;
          mem_rd    = 1'b1;
          mem_addr  = {tag_q, idx_q, cnt_q, 2'b00};
          fill_we   = 1'b1;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) begin
            fill_last       = 1'b1;
            valid_d[idx_q]  = 1'b1;
            state_d         = IDLE;
          end
        end
      endcase
    end

    // Outputs stay quiet while reset is held, whatever state is left over.
    if (!rst_n) begin
      cpu_stall = 1'b0;
      cpu_instr = '0;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      hit_evt   = 1'b0;
      miss_evt  = 1'b0;
      fill_we   = 1'b0;
      fill_last = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether
  // their contents are ever used.
  always_ff @(posedge clk) begin
    if (fill_we) data_q[idx_q][cnt_q] <= mem_rdata;
    if (fill_last) tags_q[idx_q] <= tag_q;
  end

`ifdef INST_CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif

endmodule
